// File: rtl/dlatch_bank_pkg.sv
// Shared constants and helpers for the dlatch_bank_snap channel bank and its
// snapshot buffer.
package dlatch_bank_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_DEPTH = 4;

    // Bit offset of channel idx inside a packed NCH*WIDTH bus.
    function automatic int ch_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // Occupancy counter width; it must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/snap_fifo.sv
// Circular snapshot buffer with a valid/ready drain, an occupancy count and a
// drop pulse for pushes that arrive while it is full.
module snap_fifo
    import dlatch_bank_pkg::*;
#(
    parameter int DW    = DEF_NCH * DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_req,
    input  logic [DW-1:0]            push_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (occ == CW'(DEPTH));
    assign empty = (occ == '0);
    assign pop   = out_valid && out_ready;

    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push  = push_req && (!full || pop);
    assign drop  = rstn && push_req && full && !pop;

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign count     = occ;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order the processes are evaluated.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked by
    // occ and out_data is masked to zero when empty, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (rstn && push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dlatch_bank_snap.sv
// Bank of NCH clocked hold registers with per-channel load/clear, optional
// latch-style transparency, and coherent all-channel snapshots into a buffer.
module dlatch_bank_snap
    import dlatch_bank_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NCH         = DEF_NCH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int TRANSPARENT = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NCH*WIDTH-1:0]     d,
    input  logic [NCH-1:0]           en,
    input  logic [NCH-1:0]           clr,
    output logic [NCH*WIDTH-1:0]     q,
    input  logic                     snap_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCH*WIDTH-1:0]     out_data,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     snap_drop
);

    localparam int DW = NCH * WIDTH;

    logic [DW-1:0] ch_q;
    logic [DW-1:0] ch_next;

    // NOTE: ch_next is given its full default before the loop so every bit is
    // assigned on every path and no latch is inferred.
    always_comb begin
        ch_next = ch_q;
        for (int i = 0; i < NCH; i++) begin
            if (clr[i]) begin
                ch_next[ch_lo(i, WIDTH) +: WIDTH] = '0;
            end else if (en[i]) begin
                ch_next[ch_lo(i, WIDTH) +: WIDTH] = d[ch_lo(i, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) ch_q <= '0;
        else       ch_q <= ch_next;
    end

    // In transparent mode the per-channel clr/en/hold mux is exactly ch_next,
    // which already gives clear priority over enable without touching rstn.
    generate
        if (TRANSPARENT != 0) begin : g_transparent
            assign q = ch_next;
        end else begin : g_registered
            assign q = ch_q;
        end
    endgenerate

    // Snapshots take the next-state values so they match what q shows next cycle.
    snap_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_req  (snap_req),
        .push_data (ch_next),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .drop      (snap_drop)
    );

endmodule

// File: tb/tb_dlatch_bank_snap.sv
// Directed self-checking bench for dlatch_bank_snap (registered and transparent).
module tb_dlatch_bank_snap;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int DW    = NCH * WIDTH;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] d;
    logic [NCH-1:0] en, clr;
    logic          snap_req, out_ready;

    logic [DW-1:0] q, out_data, q_t, out_data_t;
    logic          out_valid, snap_drop, out_valid_t, snap_drop_t;
    logic [2:0]    count, count_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dlatch_bank_snap #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .TRANSPARENT(0)) dut (
        .clk(clk), .rstn(rstn), .d(d), .en(en), .clr(clr), .q(q),
        .snap_req(snap_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count), .snap_drop(snap_drop)
    );

    dlatch_bank_snap #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .TRANSPARENT(1)) dut_t (
        .clk(clk), .rstn(rstn), .d(d), .en(en), .clr(clr), .q(q_t),
        .snap_req(snap_req), .out_valid(out_valid_t), .out_ready(out_ready),
        .out_data(out_data_t), .count(count_t), .snap_drop(snap_drop_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; d = '1; en = '1; clr = '0; snap_req = 1'b1; out_ready = 1'b0;
        tick(); tick();
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_q: got %h expected %h", q, 32'h0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", out_data); end
        rstn = 1'b1; en = '0; snap_req = 1'b0;
        #1;
        checks++; if (q_t !== 32'h0) begin errors++; $display("FAIL rst_qt_hold: got %h expected 0", q_t); end
        tick();
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_hold_q: got %h expected 0", q); end
    endtask

    task automatic test_load_clear();
        d = 32'h44332211; en = 4'b1111; clr = 4'b0010;
        tick();
        checks++; if (q !== 32'h44330011) begin errors++; $display("FAIL prio_q: got %h expected %h", q, 32'h44330011); end
        en = '0; clr = '0; d = 32'hDEADBEEF;
        tick();
        checks++; if (q !== 32'h44330011) begin errors++; $display("FAIL hold_q: got %h expected %h", q, 32'h44330011); end
        clr = 4'b1000;
        tick();
        clr = '0;
        checks++; if (q !== 32'h00330011) begin errors++; $display("FAIL clr_only_q: got %h expected %h", q, 32'h00330011); end
    endtask

    task automatic test_transparent();
        // Registers hold 0x00330011 on both instances here.
        en = 4'b0001; d = 32'h0000005A;
        #1;
        checks++; if (q_t[7:0] !== 8'h5A) begin errors++; $display("FAIL tr_follow_5a: got %h expected 5a", q_t[7:0]); end
        d[7:0] = 8'hA5;
        #1;
        checks++; if (q_t[7:0] !== 8'hA5) begin errors++; $display("FAIL tr_follow_a5: got %h expected a5", q_t[7:0]); end
        checks++; if (q[7:0] !== 8'h11) begin errors++; $display("FAIL tr_reg_unchanged: got %h expected 11", q[7:0]); end
        clr = 4'b0001;
        #1;
        checks++; if (q_t[7:0] !== 8'h00) begin errors++; $display("FAIL tr_clr_gate: got %h expected 00", q_t[7:0]); end
        clr = '0;
        tick();
        en = '0; d = '0;
        #1;
        checks++; if (q_t !== 32'h003300A5) begin errors++; $display("FAIL tr_hold: got %h expected %h", q_t, 32'h003300A5); end
        checks++; if (q !== 32'h003300A5) begin errors++; $display("FAIL reg_loaded: got %h expected %h", q, 32'h003300A5); end
    endtask

    task automatic test_snapshot();
        clr = '1;
        tick();
        clr = '0; en = 4'b0001; d = 32'h0000007E; snap_req = 1'b1; out_ready = 1'b0;
        tick();
        en = '0; snap_req = 1'b0; d = 32'hFFFFFFFF;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL snap_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'h0000007E) begin errors++; $display("FAIL snap_data: got %h expected %h", out_data, 32'h7E); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL snap_count: got %0d expected 1", count); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_data !== 32'h0000007E) begin errors++; $display("FAIL snap_stable%0d: got %h expected %h", k, out_data, 32'h7E); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 32'h0) begin
            errors++; $display("FAIL snap_drain: got valid=%b count=%0d data=%h expected 0/0/0", out_valid, count, out_data);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0; en = 4'b0001; snap_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d = 32'h10 + 32'(k);
            #1;
            checks++; if (snap_drop !== (k == 4)) begin errors++; $display("FAIL ovf_drop%0d: got %b expected %b", k, snap_drop, k == 4); end
            tick();
            checks++; if (count !== 3'((k < 4) ? k + 1 : 4)) begin errors++; $display("FAIL ovf_count%0d: got %0d expected %0d", k, count, (k < 4) ? k + 1 : 4); end
        end
        snap_req = 1'b0;
        #1;
        checks++; if (snap_drop !== 1'b0) begin errors++; $display("FAIL ovf_drop_clear: got %b expected 0", snap_drop); end
        checks++; if (out_data !== 32'h10) begin errors++; $display("FAIL ovf_head: got %h expected %h", out_data, 32'h10); end
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", count); end
        snap_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d = 32'h20 + 32'(k);
            out_ready = (k == 4);
            #1;
            checks++; if (snap_drop !== 1'b0) begin errors++; $display("FAIL pop_drop%0d: got %b expected 0", k, snap_drop); end
            tick();
        end
        snap_req = 1'b0; out_ready = 1'b0; en = '0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL pop_count: got %0d expected 4", count); end
        for (int k = 1; k < 5; k++) begin
            checks++; if (out_data !== 32'h20 + 32'(k)) begin errors++; $display("FAIL pop_order%0d: got %h expected %h", k, out_data, 32'h20 + 32'(k)); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        en = 4'b0001; snap_req = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = 32'h31 + 32'(k);
            tick();
        end
        snap_req = 1'b0; en = '0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", count); end
        rstn = 1'b0; out_ready = 1'b1;
        tick();
        rstn = 1'b1; out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_buf: got count=%0d valid=%b expected 0/0", count, out_valid); end
        checks++; if (out_data !== 32'h0 || q !== 32'h0) begin errors++; $display("FAIL mid_rst_zero: got data=%h q=%h expected 0/0", out_data, q); end
        en = 4'b0001; d = 32'h55; snap_req = 1'b1;
        tick();
        en = '0; snap_req = 1'b0;
        checks++; if (count !== 3'd1 || out_data !== 32'h55) begin errors++; $display("FAIL mid_fresh: got count=%0d data=%h expected 1/%h", count, out_data, 32'h55); end
    endtask

    initial begin
        test_reset();
        test_load_clear();
        test_transparent();
        test_snapshot();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlatch_bank_snap.md
Name: dlatch_bank_snap

Overview:
- Parametrised, clocked successor to the team's single-bit enable/reset data-hold element.
- Holds NCH independent channels of WIDTH bits. Each channel has its own load enable and clear.
- A snapshot request atomically captures all channels into a DEPTH-entry buffer. The buffer drains through a valid/ready handshake.
- Sits between asynchronous-ish status sources (already synchronised upstream) and a bus-side reader that samples coherent multi-channel state.

Parameters:
- WIDTH, 8: bits per channel (>=1).
- NCH, 4: number of channels (>=1).
- DEPTH, 4: snapshot buffer entries (power of two, >=2).
- TRANSPARENT, 0: 1 = q output is combinationally d while en is high (latch emulation); 0 = q is purely registered.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  reset.
- d  in  NCH*WIDTH  channel data; channel i at bits [i*WIDTH +: WIDTH].
- en  in  NCH  per-channel load enable.
- clr  in  NCH  per-channel synchronous clear.
- q  out  NCH*WIDTH  live held values.
- snap_req  in  1  capture all channels into the buffer.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  NCH*WIDTH  head snapshot.
- count  out  $clog2(DEPTH+1)  entries occupied.
- snap_drop  out  1  one-cycle pulse when a snapshot is lost to a full buffer.

Behaviour:
- Reset rstn, synchronous, active-low. While rstn=0 at a rising edge:
  - all channel registers = 0;
  - buffer emptied;
  - out_valid=0, count=0, snap_drop=0, out_data=0.
  - Other inputs are ignored during reset cycles.
- Channel register update each edge, per channel i, in priority order:
  - clr[i] -> 0;
  - else en[i] -> d[i];
  - else hold.
  - Clear beats enable when both are high.
- q output:
  - TRANSPARENT=0: q = register value. The load is visible 1 cycle after the edge at which en is sampled.
  - TRANSPARENT=1: q[i] = en[i] ? d[i] : reg[i]. clr[i] gates this to 0 combinationally, consistent with its priority.
  - No combinational path from reset; rstn=0 forces q=0 only after the edge.
- Snapshot content = next-state channel values. snap_req in the same cycle as en/clr captures the newly loaded or cleared data, i.e. exactly what q shows one cycle later.
- Buffer (circular, read/write pointers plus occupancy counter):
  - Push when snap_req=1 and (count<DEPTH or pop this cycle).
  - Pop when out_valid && out_ready.
  - Latency: snap_req at edge t gives out_valid=1 and out_data=snapshot after t. No bypass, no zero-latency path.
  - out_data = head entry when out_valid=1; 0 when empty.
  - out_data must be stable while out_valid=1 and out_ready=0.
  - Full with snap_req and no pop: snapshot discarded, snap_drop=1 for exactly that cycle, buffer unchanged.
  - Full with snap_req and simultaneous pop: accepted, count stays DEPTH, no drop.
  - Empty with out_ready=1: no effect.
  - Empty with snap_req: count->1.
  - Pointers wrap modulo DEPTH; count is saturation-free by construction.
- Reset mid-operation: all buffered snapshots are lost and channels zeroed. A pending out_ready is ignored. The first post-reset cycle behaves as empty.

Decomposition:
- Package dlatch_bank_pkg:
  - default WIDTH/NCH/DEPTH constants;
  - channel slice helper function (index -> bit offset);
  - count width constant expression.
- One sub-module: snap_fifo.
  - Parametrised data width NCH*WIDTH and depth DEPTH.
  - Synchronous active-low reset.
  - Push/pop/full/empty/count/drop.
- The channel register array and TRANSPARENT mux stay in the top module.

Test Plan:
- Reset/hold: rstn=0 two cycles with d=all 1s, en=all 1s -> q=0, out_valid=0, count=0. Then rstn=1, en=0 -> q stays 0.
- Load/clear priority: WIDTH=8, NCH=4, d=0x44332211, en=4'b1111, clr=4'b0010 -> next cycle q=0x44330011. Then en=0 -> q holds.
- Transparent mode: TRANSPARENT=1, en[0]=1, d[0] toggles 0x5A->0xA5 mid-cycle -> q[0] follows same cycle. en[0]=0 -> q[0] holds 0xA5.
- Coherent snapshot: cycle with en=4'b0001, d[0]=0x7E and snap_req=1 -> next cycle out_valid=1, out_data[7:0]=0x7E, count=1. out_ready=0 for 3 cycles -> out_data unchanged.
- Full/overflow: DEPTH=4, five snap_req back-to-back with out_ready=0 -> count=4, snap_drop=1 only on 5th cycle. Repeat with out_ready=1 on the 5th -> no drop, count=4, head advances.
- Reset mid-drain: count=3, assert rstn=0 one cycle with out_ready=1 -> count=0, out_valid=0, out_data=0, q=0. A subsequent snap_req yields a fresh single entry.
